// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int MID_SAMPLE       = 8;
    localparam int OVERSAMPLE_FIXED = 16;
    localparam int BIT_W            = $clog2(DATA_BITS);
    localparam int OS_W             = $clog2(OVERSAMPLE_FIXED);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Truncating clock divisor; oversample=1 gives the TX bit period.
    function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Two free-running dividers producing one-clk tx_tick and rx_tick strobes.
module uart_baud_tick_gen #(
    parameter int TX_DIV = 2604,
    parameter int RX_DIV = 162
) (
    input  logic clk,
    input  logic rst,
    output logic tx_tick,
    output logic rx_tick
);

    localparam int TX_W = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam int RX_W = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;

    logic [TX_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [RX_W-1:0] rx_cnt_q, rx_cnt_d;

    always_comb begin
        tx_tick  = (tx_cnt_q == TX_W'(TX_DIV - 1));
        rx_tick  = (rx_cnt_q == RX_W'(RX_DIV - 1));
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        rx_cnt_d = rx_tick ? '0 : rx_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: shared baud ticks, TX FSM and 16x oversampling RX FSM.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enb,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 rx_frame_err
);

    localparam int TX_DIV = baud_div(CLK_FREQ, BAUD, 1);
    localparam int RX_DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);

    logic tx_tick;
    logic rx_tick;

    uart_baud_tick_gen #(
        .TX_DIV(TX_DIV),
        .RX_DIV(RX_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .tx_tick(tx_tick),
        .rx_tick(rx_tick)
    );

    // ---------------- transmitter ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic                 tx_q, tx_d;
    logic                 tx_busy_q, tx_busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        if (tx_tick) begin
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (enb) begin
                        tx_shift_d = data_in;
                        tx_d       = 1'b0;
                        tx_busy_d  = 1'b1;
                        tx_state_d = TX_START;
                    end
                end
                TX_START: begin
                    tx_d       = tx_shift_q[0];
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
                TX_DATA: begin
                    if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
                        tx_d       = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    // A pending request chains straight into the next start bit.
                    if (enb) begin
                        tx_shift_d = data_in;
                        tx_d       = 1'b0;
                        tx_state_d = TX_START;
                    end else begin
                        tx_busy_d  = 1'b0;
                        tx_state_d = TX_IDLE;
                    end
                end
                default: begin
                    tx_d       = 1'b1;
                    tx_busy_d  = 1'b0;
                    tx_state_d = TX_IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;

    // ---------------- receiver ----------------
    logic [1:0]           rx_sync_q;
    logic                 rx_s;
    rx_state_e            rx_state_q, rx_state_d;
    logic [OS_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 rx_done_q, rx_done_d;
    logic                 rx_ferr_q, rx_ferr_d;

    assign rx_s = rx_sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            data_out_q <= '0;
            rx_done_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            data_out_q <= data_out_d;
            rx_done_q  <= rx_done_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        data_out_d = data_out_q;
        rx_done_d  = 1'b0;
        rx_ferr_d  = 1'b0;
        if (rx_tick) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_cnt_d   = '0;
                        rx_state_d = RX_START;
                    end
                end
                RX_START: begin
                    // Re-check at mid start bit; a high line here was only a glitch.
                    if (rx_cnt_q == OS_W'(MID_SAMPLE - 1)) begin
                        if (!rx_s) begin
                            rx_cnt_d   = '0;
                            rx_bit_d   = '0;
                            rx_state_d = RX_DATA;
                        end else begin
                            rx_state_d = RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == OS_W'(OVERSAMPLE_FIXED - 1)) begin
                        rx_cnt_d   = '0;
                        rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
                            rx_state_d = RX_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == OS_W'(OVERSAMPLE_FIXED - 1)) begin
                        if (rx_s) begin
                            data_out_d = rx_shift_q;
                            rx_done_d  = 1'b1;
                        end else begin
                            rx_ferr_d  = 1'b1;
                        end
                        rx_state_d = RX_IDLE;
                    end
                end
                default: begin
                    rx_state_d = RX_IDLE;
                end
            endcase
        end
    end

    assign data_out     = data_out_q;
    assign rx_done      = rx_done_q;
    assign rx_frame_err = rx_ferr_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at a scaled-down baud (32 clks/bit, 2 clks/rx tick).
module tb_uart_transceiver;

    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int TX_DIV   = 32;
    localparam int RX_DIV   = 2;
    localparam int CAP_LEN  = 340;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx;
    logic       tx_busy;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_done;
    logic       rx_frame_err;

    logic loop_en = 1'b0;
    logic rx_drv  = 1'b1;
    assign rx = loop_en ? tx : rx_drv;

    int total = 0;
    int bad   = 0;

    int         done_cnt  = 0;
    int         ferr_cnt  = 0;
    int         done_wide = 0;
    logic       done_prev = 1'b0;
    logic [7:0] rx_log [0:63];

    uart_transceiver #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .data_in     (data_in),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .rx          (rx),
        .data_out    (data_out),
        .rx_done     (rx_done),
        .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done) begin
            if (done_cnt < 64) rx_log[done_cnt] = data_out;
            done_cnt++;
            if (done_prev) done_wide++;
        end
        if (rx_frame_err) ferr_cnt++;
        done_prev = rx_done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!tx_busy && n < 4 * TX_DIV) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tx_busy), 32'd1);
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, done_cnt, target);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_len);
        rx_drv = 1'b0;
        repeat (TX_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (TX_DIV) @(negedge clk);
        end
        rx_drv = stop_val;
        repeat (stop_len) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    logic       tx_cap   [0:CAP_LEN-1];
    logic       busy_cap [0:CAP_LEN-1];
    logic [9:0] exp_bits;
    int         base;
    int         fbase;
    int         len;
    int         tx_lows;

    initial begin
        // Serial image of 0x67: start, 1,1,1,0,0,1,1,0, stop (bit k = k-th bit on the line).
        exp_bits = 10'b10_1100_1110;

        // Reset
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        check("rst_ferr", 32'(rx_frame_err), 32'd0);
        rst = 1'b0;
        tx_lows = 0;
        for (int i = 0; i < 20 * TX_DIV; i++) begin
            @(negedge clk);
            if (!tx) tx_lows++;
        end
        check("idle_tx_low_clks", tx_lows, 0);
        check("idle_no_done", done_cnt, 0);

        // Single loopback frame 0x67
        loop_en = 1'b1;
        fbase   = ferr_cnt;
        base    = done_cnt;
        data_in = 8'h67;
        enb     = 1'b1;
        wait_busy("lb_busy_rise");
        enb = 1'b0;
        for (int i = 0; i < CAP_LEN; i++) begin
            tx_cap[i]   = tx;
            busy_cap[i] = tx_busy;
            @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            check($sformatf("lb_bit%0d", k), 32'(tx_cap[k*TX_DIV + TX_DIV/2]), 32'(exp_bits[k]));
        end
        check("lb_start_last_clk", 32'(tx_cap[TX_DIV-1]), 32'd0);
        check("lb_bit0_first_clk", 32'(tx_cap[TX_DIV]), 32'd1);
        check("lb_busy_in_stop", 32'(busy_cap[10*TX_DIV-1]), 32'd1);
        check("lb_busy_after_stop", 32'(busy_cap[10*TX_DIV]), 32'd0);
        wait_done(base + 1, "lb_done");
        check("lb_data_out", 32'(data_out), 32'h67);
        check("lb_no_ferr", ferr_cnt, fbase);

        // Back-to-back frames: 0x0F then 0xF1, 0xF1
        base    = done_cnt;
        data_in = 8'h0F;
        enb     = 1'b1;
        wait_busy("b2b_busy_rise");
        data_in = 8'hF1;
        len = 0;
        while (tx_busy && len < 2000) begin
            len++;
            if (len == 700) enb = 1'b0;
            @(negedge clk);
        end
        check("b2b_busy_len", len, 30 * TX_DIV);
        wait_done(base + 3, "b2b_done_count");
        check("b2b_frame0", 32'(rx_log[base]), 32'h0F);
        check("b2b_frame1", 32'(rx_log[base+1]), 32'hF1);
        check("b2b_frame2", 32'(rx_log[base+2]), 32'hF1);
        check("b2b_done_width", done_wide, 0);
        check("b2b_no_ferr", ferr_cnt, fbase);

        // Glitch on rx, then a clean 0xA5
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (2 * TX_DIV) @(negedge clk);
        base  = done_cnt;
        fbase = ferr_cnt;
        rx_drv = 1'b0;
        repeat (4 * RX_DIV) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * TX_DIV) @(negedge clk);
        check("glitch_no_done", done_cnt, base);
        check("glitch_no_ferr", ferr_cnt, fbase);
        send_byte(8'hA5, 1'b1, TX_DIV);
        wait_done(base + 1, "glitch_next_done");
        check("glitch_next_data", 32'(data_out), 32'hA5);

        // Framing error on 0x3C
        repeat (2 * TX_DIV) @(negedge clk);
        base  = done_cnt;
        fbase = ferr_cnt;
        send_byte(8'h3C, 1'b0, 3 * TX_DIV / 4);
        repeat (3 * TX_DIV) @(negedge clk);
        check("ferr_pulses", ferr_cnt, fbase + 1);
        check("ferr_no_done", done_cnt, base);
        check("ferr_data_kept", 32'(data_out), 32'hA5);

        // Reset during data bit 4, then a fresh frame 0xC3
        loop_en = 1'b1;
        repeat (2 * TX_DIV) @(negedge clk);
        data_in = 8'h10;
        enb     = 1'b1;
        wait_busy("rmf_busy_rise");
        repeat (5 * TX_DIV + 10) @(negedge clk);
        check("rmf_tx_bit4", 32'(tx), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rmf_tx_high", 32'(tx), 32'd1);
        check("rmf_busy_low", 32'(tx_busy), 32'd0);
        check("rmf_data_out_cleared", 32'(data_out), 32'h00);
        repeat (3) @(negedge clk);
        base    = done_cnt;
        fbase   = ferr_cnt;
        data_in = 8'hC3;
        rst     = 1'b0;
        wait_busy("rmf_new_busy_rise");
        enb = 1'b0;
        wait_done(base + 1, "rmf_new_done");
        check("rmf_new_data", 32'(data_out), 32'hC3);
        check("rmf_no_ferr", ferr_cnt, fbase);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
Full-duplex 8N1 UART built from one shared baud-tick generator, a transmitter and a 16x-oversampling receiver. It sits between a parallel byte interface and the serial pins. tx and rx are independent pins; loopback is done outside the block. Default timing is 25 MHz clk at 9600 baud.

Parameters:
CLK_FREQ, 25000000, clk frequency in Hz
BAUD, 9600, serial bit rate
OVERSAMPLE, 16, receiver samples per bit; fixed at 16, other values unsupported
Derived constant TX_DIV = CLK_FREQ/BAUD, truncated (2604 at defaults)
Derived constant RX_DIV = CLK_FREQ/(BAUD*16), truncated (162 at defaults)

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous reset, active-high
enb  in  1  transmit request; level-sensitive
data_in  in  8  byte to transmit; sampled when a frame starts
tx  out  1  serial output; idles high
tx_busy  out  1  high from frame start until the stop bit completes
rx  in  1  serial input; asynchronous
data_out  out  8  last correctly framed received byte
rx_done  out  1  one-clk pulse when data_out updates
rx_frame_err  out  1  one-clk pulse when a stop bit is sampled low

Behaviour:
- Reset values: tx=1, tx_busy=0, data_out=8'h00, rx_done=0, rx_frame_err=0. Reset also clears all counters, shift registers and FSMs to IDLE.
- Reset asserted mid-frame aborts the frame immediately; tx returns high on the next clk.
- Baud generator: two free-running counters.
  - tx_tick is a one-clk pulse every TX_DIV clks.
  - rx_tick is a one-clk pulse every RX_DIV clks.
  - Both counters are cleared by rst.
- TX FSM states: IDLE, START, DATA, STOP. All state changes happen only on clks where tx_tick=1.
  - IDLE: if enb=1, latch data_in into the shift register, drive tx=0, go to START. tx_busy rises on the same clk.
  - START: after one bit time, drive bit0 and go to DATA.
  - DATA: shift LSB first; after bit7 has been held for one bit time, drive tx=1 and go to STOP.
  - STOP: hold tx=1 for one bit time, then go to IDLE and drop tx_busy.
  - If enb is still 1 on that IDLE tick, the next frame starts; frames are back-to-back with no extra idle bit.
  - Changes to data_in during a frame have no effect on that frame.
- RX input passes through a 2-flop synchronizer. All RX decisions below use the synchronized value and are made only on rx_tick.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a low sample, clear the tick counter and go to START.
  - START: at the 8th tick (mid-bit), if the line is still low, clear the counter and go to DATA; if it is high, treat it as a glitch and return to IDLE.
  - DATA: sample every 16th tick, shifting right so the first bit received ends up as bit0. After 8 bits, go to STOP.
  - STOP: at the 16th tick, sample the line.
    - If high: load data_out from the shift register and pulse rx_done for one clk.
    - If low: pulse rx_frame_err and leave data_out unchanged.
    - Either way, return to IDLE.
- A stuck-low line after a framing error starts a new frame attempt. No break detection.
- Baud mismatch between TX_DIV and 16*RX_DIV is at most one RX_DIV period per bit (0.46% at defaults), which is acceptable.
- Latency, loopback: rx_done asserts about 9.5 bit times after the TX start edge, plus 2-3 clks for the synchronizer.

Decomposition:
- Package uart_pkg holds:
  - the TX and RX state enums
  - frame constants DATA_BITS=8 and MID_SAMPLE=8
  - a divisor function computing TX_DIV and RX_DIV from CLK_FREQ and BAUD.
- One sub-module, uart_baud_tick_gen, produces tx_tick and rx_tick.
- The TX and RX FSMs live in the top level, each about 60-100 lines.

Test Plan:
- Reset: hold rst=1 for 5 clks -> tx=1, tx_busy=0, data_out=00, no pulses. Release with enb=0 for 3 ms -> tx stays 1.
- Loopback 0x67 with tx tied to rx, enb=1 -> tx bit sequence 0,1,1,1,0,0,1,1,0,1, each bit TX_DIV clks wide. rx_done pulses, data_out=67, rx_frame_err=0.
- Back-to-back: enb held 1, data_in changed to F1 after the first frame -> subsequent frames deliver data_out=F1. Each rx_done is exactly one clk. No idle gap between frames.
- Glitch: drive rx low for 4*RX_DIV clks, then high -> no rx_done, RX back in IDLE, next valid frame 0xA5 received correctly.
- Framing error: send 0x3C with the stop bit forced low -> rx_frame_err pulses once, rx_done stays 0, data_out keeps its previous value.
- Reset mid-frame: assert rst during data bit 4 of a TX frame -> tx=1 on the next clk, tx_busy=0. After release with enb=1, a complete new frame is sent and received intact.
